char_ram_arb: RTL and testbench
===============================

Name: char_ram_arb

Overview:
- Single-port arbiter/sequencer for the 16-bit character RAM (char/attribute cells) in the clk25 domain.
- Replaces the write-enable address mux and shares the RAM between three requesters: the VGA character fetch (read), CPU GPIO-d writes (buffered in a small FIFO), and a hardware screen-clear engine.
- The VGA fetch never stalls, CPU writes are never silently lost, and the clear engine uses only idle slots.

Parameters:
- AW, 13, cell address width.
- DW, 16, cell data width ({RGB[7:0], ascii[7:0]}).
- FIFO_DEPTH, 4, CPU write FIFO entries; power of two, at least 2.
- CELLS, 4800, cells swept by the clear engine (80x60).

Ports:
- clk, in, 1: clk25; all state on rising edge.
- rst, in, 1: asynchronous, active-low reset.
- vga_req, in, 1: fetch request for vga_address, one cycle per request.
- vga_address, in, AW: cell to read.
- vga_data, out, DW: fetched cell; valid when vga_valid=1.
- vga_valid, out, 1: one-cycle strobe.
- cpu_we, in, 1: CPU write request.
- cpu_address, in, AW: write address.
- cpu_wdata, in, DW: write data.
- cpu_busy, out, 1: FIFO full.
- ovf, out, 1: sticky; a write was dropped.
- clr_start, in, 1: start clear pulse.
- clr_value, in, DW: fill value, latched at start.
- clr_busy, out, 1: clear in progress.
- clr_done, out, 1: one-cycle strobe when the last cell is written.
- ram_addr, out, AW: registered RAM address.
- ram_din, out, DW: registered RAM write data.
- ram_we, out, 1: registered RAM write enable.
- ram_dout, in, DW: RAM read data, one cycle after the address edge.

Behaviour:
- Reset (rst=0, async): FIFO empty, all pointers 0, clr_ptr=0.
  - Outputs: ram_addr=0, ram_din=0, ram_we=0, vga_valid=0, cpu_busy=0, ovf=0, clr_busy=0, clr_done=0.
  - A clear in progress is aborted; FIFO contents are discarded.
- Slot grant, decided from inputs sampled at the edge ending cycle n; fixed priority:
  1. vga_req=1: read slot. Cycle n+1 has ram_addr=vga_address (latched), ram_we=0.
  2. FIFO not empty: write slot. Cycle n+1 has ram_addr/ram_din = FIFO head, ram_we=1; head popped at the same edge.
  3. clr_busy=1: clear slot. Cycle n+1 has ram_addr=clr_ptr, ram_din=clr_value latch, ram_we=1; clr_ptr increments.
  4. Otherwise ram_we=0 and ram_addr holds its value.
- VGA read latency: vga_req in cycle n gives vga_valid=1 in cycle n+2.
  - vga_data is a pass-through of ram_dout and is only meaningful while vga_valid=1.
  - Back-to-back vga_req gives back-to-back vga_valid.
- CPU FIFO:
  - A push happens when cpu_we=1 and cpu_busy=0 at the edge.
  - cpu_busy = (count==FIFO_DEPTH), registered from the count.
  - Push and pop in the same cycle: count is unchanged and order is preserved.
  - cpu_we=1 while cpu_busy=1: the write is dropped and ovf sets, even if a pop occurs in that cycle. ovf clears only on reset.
  - Writes reach the RAM in arrival order.
- Clear engine:
  - clr_start=1 with clr_busy=0: latch clr_value, clr_ptr=0, clr_busy=1 on the next cycle.
  - clr_start while clr_busy=1 is ignored.
  - When the clear slot for address CELLS-1 is issued: clr_busy=0, and clr_done=1 for exactly one cycle (the cycle in which that write is on the RAM port).
  - A CPU write that lands during a clear may be overwritten later by the clear; this is intended. Software waits for clr_busy=0.
- Address arithmetic: clr_ptr is AW bits and never exceeds CELLS-1, so there is no wrap. FIFO pointers wrap modulo FIFO_DEPTH.
- Starvation: VGA requests at most 1 per 8 cycles in normal use. With continuous vga_req, the FIFO and clear engine stall indefinitely; this is legal.

Test Plan:
- VGA read latency: preload cell 0x0010=0x1C41; vga_req with vga_address=0x0010 in cycle n → vga_valid=1 and vga_data=0x1C41 in cycle n+2 only.
- Same-cycle collision: vga_req and cpu_we(0x0005, 0x0F58) in the same cycle → read slot in n+1, write slot in n+2 (ram_we=1, ram_addr=0x0005). A later read of 0x0005 returns 0x0F58.
- FIFO full: with vga_req held high, write 4 entries → cpu_busy=1. A 5th write is dropped and ovf=1. Release vga_req → 4 writes issue on consecutive cycles in order, cpu_busy drops after the first pop.
- Full clear, no contention: clr_start with clr_value=0x0020 → clr_busy=1, 4800 consecutive writes to 0..4799, clr_done pulses once with ram_addr=4799, clr_busy=0. A second clr_start mid-sweep has no effect.
- Clear interleave: vga_req every 8th cycle during a clear → no clear write occupies a VGA slot, every vga_valid arrives at n+2, and the total sweep takes 4800 + (number of VGA slots) cycles.
- Reset mid-operation: assert rst low mid-clear with 2 FIFO entries → all outputs return to reset values immediately. After release, no further writes are issued and clr_ptr=0.

Source files
------------

// File: rtl/char_ram_arb.sv
// Character RAM sequencer: shares one RAM port between VGA fetch,
// buffered CPU writes and a screen-clear engine, in that priority.
module char_ram_arb #(
  parameter int AW         = 13,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CELLS      = 4800
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_address,
  output logic [DW-1:0] vga_data,
  output logic          vga_valid,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_busy,
  output logic          ovf,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_value,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST = AW'(CELLS - 1);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

  logic [AW-1:0] fa_mem [FIFO_DEPTH];
  logic [DW-1:0] fd_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;
  logic [AW-1:0] clr_ptr;
  logic [DW-1:0] clr_val;
  logic          rd_slot;
  logic          push;
  logic          g_rd;
  logic          g_wr;
  logic          g_clr;
  logic          empty;

  assign empty = (count == '0);
  assign push  = cpu_we && !cpu_busy;
  assign g_rd  = vga_req;
  assign g_wr  = !vga_req && !empty;
  assign g_clr = !vga_req && empty && clr_busy;

  assign vga_data = ram_dout;

  always_comb begin
    count_nxt = count + (PW+1)'(push) - (PW+1)'(g_wr);
  end

  // FIFO storage is not reset; reset only discards it via the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      fa_mem[wr_ptr] <= cpu_address;
      fd_mem[wr_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      cpu_busy <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (g_wr) rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      cpu_busy <= (count_nxt == FULL);
      if (cpu_we && cpu_busy) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we    <= 1'b0;
      rd_slot   <= 1'b0;
      vga_valid <= 1'b0;
    end else begin
      rd_slot   <= g_rd;
      vga_valid <= rd_slot;
      ram_we    <= 1'b0;
      unique case (1'b1)
        g_rd: begin
          ram_addr <= vga_address;
        end
        g_wr: begin
          ram_addr <= fa_mem[rd_ptr];
          ram_din  <= fd_mem[rd_ptr];
          ram_we   <= 1'b1;
        end
        g_clr: begin
          ram_addr <= clr_ptr;
          ram_din  <= clr_val;
          ram_we   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_ptr  <= '0;
      clr_val  <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      if (g_clr) begin
        if (clr_ptr == LAST) begin
          clr_ptr  <= '0;
          clr_busy <= 1'b0;
          clr_done <= 1'b1;
        end else begin
          clr_ptr <= clr_ptr + 1'b1;
        end
      end else if (clr_start && !clr_busy) begin
        clr_ptr  <= '0;
        clr_val  <= clr_value;
        clr_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_char_ram_arb.sv
// Directed bench for char_ram_arb with a behavioural single-port RAM
// hung off the ram_* port.
module tb_char_ram_arb;

  logic        clk;
  logic        rst;
  logic        vga_req;
  logic [12:0] vga_address;
  logic [15:0] vga_data;
  logic        vga_valid;
  logic        cpu_we;
  logic [12:0] cpu_address;
  logic [15:0] cpu_wdata;
  logic        cpu_busy;
  logic        ovf;
  logic        clr_start;
  logic [15:0] clr_value;
  logic        clr_busy;
  logic        clr_done;
  logic [12:0] ram_addr;
  logic [15:0] ram_din;
  logic        ram_we;
  logic [15:0] ram_dout;

  logic [15:0] mem [0:8191];

  int total;
  int bad;

  typedef struct {
    logic        vr;
    logic [12:0] va;
    logic        cw;
    logic [12:0] ca;
    logic [15:0] cd;
    logic        ew;
    logic [12:0] ea;
    logic [15:0] ed;
    logic        ev;
    logic        dchk;
    logic [15:0] evd;
    logic        eb;
    logic        eo;
  } vec_t;

  vec_t tv [23];

  char_ram_arb dut (
    .clk(clk),
    .rst(rst),
    .vga_req(vga_req),
    .vga_address(vga_address),
    .vga_data(vga_data),
    .vga_valid(vga_valid),
    .cpu_we(cpu_we),
    .cpu_address(cpu_address),
    .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy),
    .ovf(ovf),
    .clr_start(clr_start),
    .clr_value(clr_value),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
    .ram_addr(ram_addr),
    .ram_din(ram_din),
    .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    vga_req   = 1'b0;
    cpu_we    = 1'b0;
    clr_start = 1'b0;
  endtask

  initial begin
    int ptr, first, last, done_cnt, seq_err, done_err;
    int nrd, nwr, slot_err, vv_err, done_k, wcnt, bcnt;
    logic prev, cur;

    total = 0;
    bad   = 0;
    rst   = 1'b0;
    vga_address = '0;
    cpu_address = '0;
    cpu_wdata   = '0;
    clr_value   = '0;
    idle_in();

    //             vr va      cw ca      cd       ew ea      ed       ev dk evd      eb eo
    tv[0]  = '{0, 13'h0,   0, 13'h0,   16'h0,   0, 13'h010, 16'h0,   0, 0, 16'h0,   0, 0};
    tv[1]  = '{1, 13'h010, 0, 13'h0,   16'h0,   0, 13'h010, 16'h0,   0, 0, 16'h0,   0, 0};
    tv[2]  = '{0, 13'h0,   0, 13'h0,   16'h0,   0, 13'h010, 16'h0,   1, 1, 16'h1C41, 0, 0};
    tv[3]  = '{0, 13'h0,   0, 13'h0,   16'h0,   0, 13'h010, 16'h0,   0, 0, 16'h0,   0, 0};
    tv[4]  = '{1, 13'h005, 1, 13'h005, 16'h0F58, 0, 13'h005, 16'h0,  0, 0, 16'h0,   0, 0};
    tv[5]  = '{0, 13'h0,   0, 13'h0,   16'h0,   1, 13'h005, 16'h0F58, 1, 0, 16'h0,  0, 0};
    tv[6]  = '{1, 13'h005, 0, 13'h0,   16'h0,   0, 13'h005, 16'h0,   0, 0, 16'h0,   0, 0};
    tv[7]  = '{0, 13'h0,   0, 13'h0,   16'h0,   0, 13'h005, 16'h0,   1, 1, 16'h0F58, 0, 0};
    tv[8]  = '{0, 13'h0,   0, 13'h0,   16'h0,   0, 13'h005, 16'h0,   0, 0, 16'h0,   0, 0};
    tv[9]  = '{1, 13'h010, 1, 13'h100, 16'hA001, 0, 13'h010, 16'h0,  0, 0, 16'h0,   0, 0};
    tv[10] = '{1, 13'h010, 1, 13'h101, 16'hA002, 0, 13'h010, 16'h0,  1, 1, 16'h1C41, 0, 0};
    tv[11] = '{1, 13'h010, 1, 13'h102, 16'hA003, 0, 13'h010, 16'h0,  1, 1, 16'h1C41, 0, 0};
    tv[12] = '{1, 13'h010, 1, 13'h103, 16'hA004, 0, 13'h010, 16'h0,  1, 1, 16'h1C41, 1, 0};
    tv[13] = '{1, 13'h010, 1, 13'h104, 16'hA005, 0, 13'h010, 16'h0,  1, 1, 16'h1C41, 1, 1};
    tv[14] = '{0, 13'h0,   0, 13'h0,   16'h0,   1, 13'h100, 16'hA001, 1, 1, 16'h1C41, 0, 1};
    tv[15] = '{0, 13'h0,   0, 13'h0,   16'h0,   1, 13'h101, 16'hA002, 0, 0, 16'h0,  0, 1};
    tv[16] = '{0, 13'h0,   0, 13'h0,   16'h0,   1, 13'h102, 16'hA003, 0, 0, 16'h0,  0, 1};
    tv[17] = '{0, 13'h0,   0, 13'h0,   16'h0,   1, 13'h103, 16'hA004, 0, 0, 16'h0,  0, 1};
    tv[18] = '{0, 13'h0,   0, 13'h0,   16'h0,   0, 13'h103, 16'h0,   0, 0, 16'h0,   0, 1};
    tv[19] = '{0, 13'h0,   1, 13'h200, 16'hB001, 0, 13'h103, 16'h0,  0, 0, 16'h0,   0, 1};
    tv[20] = '{0, 13'h0,   1, 13'h201, 16'hB002, 1, 13'h200, 16'hB001, 0, 0, 16'h0, 0, 1};
    tv[21] = '{0, 13'h0,   0, 13'h0,   16'h0,   1, 13'h201, 16'hB002, 0, 0, 16'h0,  0, 1};
    tv[22] = '{0, 13'h0,   0, 13'h0,   16'h0,   0, 13'h201, 16'h0,   0, 0, 16'h0,   0, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("rst.ram_we", 32'(ram_we), 0);
    chk("rst.ram_addr", 32'(ram_addr), 0);
    chk("rst.ram_din", 32'(ram_din), 0);
    chk("rst.vga_valid", 32'(vga_valid), 0);
    chk("rst.cpu_busy", 32'(cpu_busy), 0);
    chk("rst.ovf", 32'(ovf), 0);
    chk("rst.clr_busy", 32'(clr_busy), 0);
    chk("rst.clr_done", 32'(clr_done), 0);

    // preload cell 0x0010 through the CPU path
    cpu_we = 1'b1;
    cpu_address = 13'h010;
    cpu_wdata = 16'h1C41;
    step();
    cpu_we = 1'b0;
    step();
    step();

    for (int i = 0; i < 23; i++) begin
      vga_req     = tv[i].vr;
      vga_address = tv[i].va;
      cpu_we      = tv[i].cw;
      cpu_address = tv[i].ca;
      cpu_wdata   = tv[i].cd;
      step();
      chk($sformatf("v%0d.we", i), 32'(ram_we), 32'(tv[i].ew));
      chk($sformatf("v%0d.addr", i), 32'(ram_addr), 32'(tv[i].ea));
      if (tv[i].ew)
        chk($sformatf("v%0d.din", i), 32'(ram_din), 32'(tv[i].ed));
      chk($sformatf("v%0d.vv", i), 32'(vga_valid), 32'(tv[i].ev));
      if (tv[i].ev && tv[i].dchk)
        chk($sformatf("v%0d.vdata", i), 32'(vga_data), 32'(tv[i].evd));
      chk($sformatf("v%0d.busy", i), 32'(cpu_busy), 32'(tv[i].eb));
      chk($sformatf("v%0d.ovf", i), 32'(ovf), 32'(tv[i].eo));
    end
    idle_in();

    // full clear without contention, second start mid-sweep ignored
    clr_value = 16'h0020;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    chk("clr.busy_start", 32'(clr_busy), 1);
    chk("clr.no_write_start", 32'(ram_we), 0);
    ptr = 0; first = -1; last = -1; done_cnt = 0;
    seq_err = 0; done_err = 0;
    for (int c = 0; c < 6000; c++) begin
      if (c == 100) begin
        clr_start = 1'b1;
        clr_value = 16'h1111;
      end else begin
        clr_start = 1'b0;
      end
      step();
      if (ram_we) begin
        if (ram_addr != 13'(ptr) || ram_din != 16'h0020) seq_err++;
        if (first < 0) first = c;
        ptr++;
      end
      if (clr_done) begin
        done_cnt++;
        if (!ram_we || ram_addr != 13'd4799) done_err++;
        last = c;
      end
      if (!clr_busy) break;
    end
    clr_start = 1'b0;
    chk("clr.seq_err", 32'(seq_err), 0);
    chk("clr.nwrites", 32'(ptr), 4800);
    chk("clr.done_cnt", 32'(done_cnt), 1);
    chk("clr.done_addr_err", 32'(done_err), 0);
    chk("clr.span", 32'(last - first), 4799);
    chk("clr.busy_end", 32'(clr_busy), 0);
    step();
    chk("clr.done_once", 32'(clr_done), 0);
    chk("clr.idle_we", 32'(ram_we), 0);
    chk("clr.mem0", 32'(mem[0]), 16'h0020);
    chk("clr.mem4799", 32'(mem[4799]), 16'h0020);

    // clear interleaved with a VGA fetch every 8th cycle
    clr_value = 16'h0033;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    vga_address = 13'h010;
    prev = 1'b0; nrd = 0; nwr = 0; slot_err = 0; vv_err = 0; done_k = -1;
    for (int k = 0; k < 6000; k++) begin
      vga_req = (k % 8 == 4);
      step();
      cur = vga_req;
      if (cur) begin
        nrd++;
        if (ram_we || ram_addr != 13'h010) slot_err++;
      end
      if (ram_we) nwr++;
      if (vga_valid !== prev) vv_err++;
      prev = cur;
      if (clr_done) begin
        done_k = k;
        break;
      end
    end
    vga_req = 1'b0;
    chk("ilv.slot_err", 32'(slot_err), 0);
    chk("ilv.vv_err", 32'(vv_err), 0);
    chk("ilv.nwrites", 32'(nwr), 4800);
    chk("ilv.span", 32'(done_k + 1), 32'(4800 + nrd));
    step();
    step();

    // reset in the middle of a clear with two FIFO entries pending
    clr_value = 16'h0044;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (20) step();
    vga_req = 1'b1;
    vga_address = 13'h010;
    cpu_we = 1'b1;
    cpu_address = 13'h300;
    cpu_wdata = 16'hC001;
    step();
    cpu_address = 13'h301;
    cpu_wdata = 16'hC002;
    step();
    cpu_we = 1'b0;
    chk("mid.clr_busy", 32'(clr_busy), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst.ram_we", 32'(ram_we), 0);
    chk("mrst.ram_addr", 32'(ram_addr), 0);
    chk("mrst.ram_din", 32'(ram_din), 0);
    chk("mrst.vga_valid", 32'(vga_valid), 0);
    chk("mrst.cpu_busy", 32'(cpu_busy), 0);
    chk("mrst.ovf", 32'(ovf), 0);
    chk("mrst.clr_busy", 32'(clr_busy), 0);
    chk("mrst.clr_done", 32'(clr_done), 0);
    vga_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wcnt = 0;
    bcnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (ram_we) wcnt++;
      if (clr_busy) bcnt++;
    end
    chk("post.no_writes", 32'(wcnt), 0);
    chk("post.no_clear", 32'(bcnt), 0);

    // a fresh clear after reset starts from cell 0
    clr_value = 16'h0055;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    step();
    chk("post.first_we", 32'(ram_we), 1);
    chk("post.first_addr", 32'(ram_addr), 0);
    chk("post.first_din", 32'(ram_din), 16'h0055);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
